fir_engine: RTL and testbench

//  11-tap FIR datapath. Sits directly upstream of the two bram12 instances and drives their ports.
//  tap BRAM: read-only from here; coefficients are written by the AXI-Lite block.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_mac.sv | 52 +++++
 rtl/fir_engine.sv | 169 ++++++++++++++++
 tb/tb_fir_engine.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and address helper for the 11-tap FIR engine.
// Optional feature macro: FIR_SAT_EN (saturating accumulate, see fir_mac).
package fir_pkg;

  localparam int NUM_TAP = 11;  // tap count and history depth in words (<= 12)
  localparam int DW      = 32;  // sample / tap / result width
  localparam int AW      = 12;  // BRAM byte-address width
  localparam int KW      = 4;   // width of tap index / head pointer, holds 0..NUM_TAP

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    MAC,
    OUT,
    DONE
  } state_e;

  // Word index to BRAM byte address (word w lives at byte w*4).
  function automatic logic [AW-1:0] word_addr(input logic [KW-1:0] w);
    word_addr = {{(AW-KW-2){1'b0}}, w, 2'b00};
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate unit: low-DW-bit signed product added into an accumulator.
// Macro FIR_SAT_EN: when defined each accumulate saturates to the signed DW range,
// otherwise the accumulator wraps modulo 2^DW. Product truncation is the same in both.
module fir_mac
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [DW-1:0] i_tap,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_acc
);

  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_prod;
  logic [DW-1:0] w_next;

  // The low DW bits of a product are identical for signed and unsigned operands.
  assign w_prod = i_tap * i_data;

`ifdef FIR_SAT_EN
  logic [DW:0] w_sum;

  assign w_sum = {r_acc[DW-1], r_acc} + {w_prod[DW-1], w_prod};

  // Clamp to the signed range when the sign-extended sum overflows DW bits.
  always_comb begin
    w_next = w_sum[DW-1:0];
    if (w_sum[DW] != w_sum[DW-1]) begin
      w_next = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign w_next = r_acc + w_prod;
`endif

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_engine.sv
// 11-tap FIR engine: streams samples in, keeps a circular history in the data BRAM,
// reads coefficients from the tap BRAM and streams one result out per sample.
// Macro FIR_SAT_EN selects the saturating accumulator inside fir_mac.
//
// Stream handshakes: a beat transfers on a rising clock edge where both valid and
// ready are 1. ss_tready is 1 only in WAIT_IN. sm_tvalid is 1 only in OUT, and
// sm_tdata/sm_tlast do not change while sm_tvalid=1 and sm_tready=0.
module fir_engine
  import fir_pkg::*;
(
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  output logic          ap_idle,
  output logic          ap_done,
  input  logic          ss_tvalid,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          ss_tready,
  output logic          sm_tvalid,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast,
  input  logic          sm_tready,
  output logic          tap_EN,
  output logic [AW-1:0] tap_A,
  input  logic [DW-1:0] tap_Do,
  output logic          data_EN,
  output logic [3:0]    data_WE,
  output logic [AW-1:0] data_A,
  output logic [DW-1:0] data_Di,
  input  logic [DW-1:0] data_Do,
  output state_e        o_dbg_state
);

  state_e        r_state;
  state_e        w_next_state;
  logic [KW-1:0] r_k;       // CLEAR word index / MAC cycle index
  logic [KW-1:0] r_head;    // history slot of the newest sample
  logic [31:0]   r_count;   // results delivered this run
  logic [31:0]   r_len;     // run length latched at start
  logic [KW-1:0] w_idx;
  logic [31:0]   w_count_inc;
  logic          w_ss_hs;
  logic          w_mac_en;
  logic [DW-1:0] w_acc;
  logic          w_unused;

  // Run length comes from data_length, so the input tlast carries no information.
  assign w_unused    = ss_tlast;

  assign w_ss_hs     = (r_state == WAIT_IN) && ss_tvalid;
  assign w_count_inc = r_count + 32'd1;
  // Modulo-16 arithmetic gives (head - k) mod NUM_TAP because the true result is below 16.
  assign w_idx       = (r_head >= r_k) ? (r_head - r_k) : (r_head + KW'(NUM_TAP) - r_k);
  // Read data for cycle k arrives in cycle k+1, so accumulate from k=1 to k=NUM_TAP.
  assign w_mac_en    = (r_state == MAC) && (r_k != '0);
  assign o_dbg_state = r_state;

  fir_mac u_mac (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .i_clear (w_ss_hs),
    .i_en    (w_mac_en),
    .i_tap   (tap_Do),
    .i_data  (data_Do),
    .o_acc   (w_acc)
  );

  // State register plus index, head, counter and run-length bookkeeping.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_head  <= '0;
      r_count <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_len   <= data_length;
            r_k     <= '0;
            r_count <= '0;
          end
        end
        CLEAR: begin
          r_head <= '0;
          r_k    <= (r_k == KW'(NUM_TAP - 1)) ? '0 : r_k + KW'(1);
        end
        MAC: begin
          if (r_k == KW'(NUM_TAP)) begin
            r_k    <= '0;
            r_head <= (r_head == KW'(NUM_TAP - 1)) ? '0 : r_head + KW'(1);
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        OUT: begin
          if (sm_tready) r_count <= w_count_inc;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and all registered-state-driven outputs, including BRAM ports.
  always_comb begin
    w_next_state = r_state;
    ap_idle      = 1'b0;
    ap_done      = 1'b0;
    ss_tready    = 1'b0;
    sm_tvalid    = 1'b0;
    sm_tdata     = '0;
    sm_tlast     = 1'b0;
    tap_EN       = 1'b0;
    tap_A        = '0;
    data_EN      = 1'b0;
    data_WE      = 4'h0;
    data_A       = '0;
    data_Di      = '0;
    case (r_state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) w_next_state = CLEAR;
      end
      CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(r_k);
        if (r_k == KW'(NUM_TAP - 1)) w_next_state = (r_len == 32'd0) ? DONE : WAIT_IN;
      end
      WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN      = 1'b1;
          data_WE      = 4'hF;
          data_A       = word_addr(r_head);
          data_Di      = ss_tdata;
          w_next_state = MAC;
        end
      end
      MAC: begin
        // Enables stay high in the last cycle because read data is gated by EN.
        tap_EN  = 1'b1;
        data_EN = 1'b1;
        if (r_k != KW'(NUM_TAP)) begin
          tap_A  = word_addr(r_k);
          data_A = word_addr(w_idx);
        end else begin
          w_next_state = OUT;
        end
      end
      OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = w_acc;
        sm_tlast  = (w_count_inc == r_len);
        if (sm_tready) w_next_state = (w_count_inc == r_len) ? DONE : WAIT_IN;
      end
      DONE: begin
        ap_done      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_engine.sv
// Bench for fir_engine: two 12-word BRAM models, a FIR reference model feeding an
// expected-result queue, and one task per scenario.
module tb_fir_engine;
  import fir_pkg::*;

  // ---------------- clock / reset / DUT signals ----------------
  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic [31:0]   data_length = '0;
  logic          ap_idle, ap_done;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tlast = 1'b0;
  logic          ss_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          sm_tready = 1'b0;
  logic          tap_EN, data_EN;
  logic [AW-1:0] tap_A, data_A;
  logic [DW-1:0] tap_Do, data_Do, data_Di;
  logic [3:0]    data_WE;
  state_e        dbg_state;

  always #5 axis_clk = ~axis_clk;

  fir_engine dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ss_tvalid   (ss_tvalid),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .sm_tready   (sm_tready),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .data_EN     (data_EN),
    .data_WE     (data_WE),
    .data_A      (data_A),
    .data_Di     (data_Di),
    .data_Do     (data_Do),
    .o_dbg_state (dbg_state)
  );

  // ---------------- BRAM models (1-cycle read, Do gated by EN) ----------------
  logic [DW-1:0] tap_mem  [0:15];
  logic [DW-1:0] data_mem [0:15];
  logic [DW-1:0] tap_q, data_q;
  logic [3:0]    tap_w, data_w;

  assign tap_w  = 4'(tap_A >> 2);
  assign data_w = 4'(data_A >> 2);

  always @(posedge axis_clk) begin
    if (tap_EN) tap_q <= tap_mem[tap_w];
  end

  always @(posedge axis_clk) begin
    if (data_EN) begin
      data_q <= data_mem[data_w];
      for (int b = 0; b < 4; b++) begin
        if (data_WE[b]) data_mem[data_w][8*b +: 8] <= data_Di[8*b +: 8];
      end
    end
  end

  assign tap_Do  = tap_EN  ? tap_q  : '0;
  assign data_Do = data_EN ? data_q : '0;

  // ---------------- scoreboard and reference model ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_hist [0:NUM_TAP-1];
  int            m_head;

  function automatic logic [DW-1:0] model_y();
    logic [DW-1:0] acc = '0;
    logic [DW-1:0] p;
    longint        s;
    for (int k = 0; k < NUM_TAP; k++) begin
      p = tap_mem[k] * m_hist[(m_head - k + NUM_TAP) % NUM_TAP];
`ifdef FIR_SAT_EN
      s = longint'($signed(acc)) + longint'($signed(p));
      if (s > 64'sh7FFFFFFF)       acc = 32'h7FFFFFFF;
      else if (s < -64'sh80000000) acc = 32'h80000000;
      else                         acc = s[31:0];
`else
      acc = acc + p;
`endif
    end
    return acc;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_TAP; i++) m_hist[i] = '0;
    m_head = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [DW-1:0] x);
    m_hist[m_head] = x;
    exp_q.push_back(model_y());
    m_head = (m_head + 1) % NUM_TAP;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [31:0] len);
    @(negedge axis_clk);
    data_length = len;
    ap_start    = 1'b1;
    @(negedge axis_clk);
    ap_start    = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] x, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge axis_clk);
      if (ss_tready) begin
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        model_push(x);
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
        ss_tdata  = $urandom;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sm_tvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge axis_clk);
    end
  endtask

  task automatic take_result(output logic [DW-1:0] d, output logic l, output bit ok);
    wait_valid(ok);
    d = sm_tdata;
    l = sm_tlast;
    if (ok) begin
      sm_tready = 1'b1;
      @(negedge axis_clk);
      sm_tready = 1'b0;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (ap_done) n++;
      @(negedge axis_clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    axis_rst = 1'b1;
    repeat (3) @(negedge axis_clk);
    n_cmp++;
    if (dbg_state !== IDLE || ap_idle !== 1'b1) begin
      n_bad++; $display("FAIL reset_idle: state=%0d ap_idle=%b, required state=0 ap_idle=1", dbg_state, ap_idle);
    end
    n_cmp++;
    if ({ap_done, ss_tready, sm_tvalid, sm_tlast} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 0000", {ap_done, ss_tready, sm_tvalid, sm_tlast});
    end
    n_cmp++;
    if ({tap_EN, data_EN, data_WE} !== 6'b0) begin
      n_bad++; $display("FAIL reset_bram_ctl: got %b required 000000", {tap_EN, data_EN, data_WE});
    end
    n_cmp++;
    if ({sm_tdata, tap_A, data_A, data_Di} !== '0) begin
      n_bad++; $display("FAIL reset_data: sm_tdata=%h tap_A=%h data_A=%h data_Di=%h required all 0", sm_tdata, tap_A, data_A, data_Di);
    end
    axis_rst = 1'b0;
    @(negedge axis_clk);
  endtask

  task automatic test_impulse();
    logic [DW-1:0] d, e;
    logic l;
    bit ok;
    int c, nd;
    for (int k = 0; k < NUM_TAP; k++) tap_mem[k] = DW'(k + 1);
    model_clear();
    start_run(32'd11);
    for (int i = 0; i < 11; i++) begin
      send_sample((i == 0) ? 32'd1 : 32'd0, ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL impulse_in: no ss_tready for sample %0d", i); return; end
      if (i == 0) begin
        c = 0;
        while (!sm_tvalid && c < 40) begin @(negedge axis_clk); c++; end
        n_cmp++;
        if (c !== NUM_TAP + 1) begin n_bad++; $display("FAIL impulse_latency: got %0d cycles required %0d", c, NUM_TAP + 1); end
      end
      take_result(d, l, ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL impulse_out: no sm_tvalid for sample %0d", i); return; end
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== e) begin n_bad++; $display("FAIL impulse_y%0d: got %h required %h", i, d, e); end
      n_cmp++;
      if (l !== (i == 10)) begin n_bad++; $display("FAIL impulse_tlast%0d: got %b required %b", i, l, (i == 10)); end
    end
    count_done(6, nd);
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL impulse_done: got %0d pulses required 1", nd); end
  endtask

  task automatic test_second_run();
    logic [DW-1:0] d;
    logic l;
    bit ok;
    int nd;
    model_clear();
    start_run(32'd1);
    send_sample(32'd5, ok);
    take_result(d, l, ok);
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL second_out: no sm_tvalid"); return; end
    void'(exp_q.pop_front());
    n_cmp++;
    if (d !== 32'd5 || l !== 1'b1) begin n_bad++; $display("FAIL second_y: got %h last=%b required 00000005 last=1", d, l); end
    count_done(6, nd);
    n_cmp++;
    if (nd !== 1 || ap_idle !== 1'b1) begin n_bad++; $display("FAIL second_idle: done=%0d ap_idle=%b required 1 and 1", nd, ap_idle); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d, e;
    logic l;
    bit ok;
    int nd;
    for (int k = 0; k < NUM_TAP; k++) tap_mem[k] = DW'($urandom_range(2000)) - 32'd1000;
    model_clear();
    start_run(32'd2);
    send_sample($urandom, ok);
    wait_valid(ok);
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL stall_out: no sm_tvalid"); return; end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (sm_tdata !== e || sm_tvalid !== 1'b1 || ss_tready !== 1'b0 || sm_tlast !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold%0d: tdata=%h tvalid=%b ss_tready=%b tlast=%b required %h 1 0 0", i, sm_tdata, sm_tvalid, ss_tready, sm_tlast, e);
      end
      @(negedge axis_clk);
    end
    sm_tready = 1'b1;
    @(negedge axis_clk);
    sm_tready = 1'b0;
    send_sample($urandom, ok);
    take_result(d, l, ok);
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL stall_out2: no sm_tvalid"); return; end
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== e || l !== 1'b1) begin n_bad++; $display("FAIL stall_y1: got %h last=%b required %h last=1", d, l, e); end
    count_done(6, nd);
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL stall_done: got %0d pulses required 1", nd); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d, e;
    logic l;
    bit ok;
    int nd;
    for (int k = 0; k < NUM_TAP; k++) tap_mem[k] = 32'd1;
    model_clear();
    start_run(32'd25);
    for (int i = 0; i < 25; i++) begin
      send_sample(32'd1, ok);
      take_result(d, l, ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL wrap_out: no sm_tvalid for sample %0d", i); return; end
      void'(exp_q.pop_front());
      e = (i < NUM_TAP) ? DW'(i + 1) : DW'(NUM_TAP);
      n_cmp++;
      if (d !== e || l !== (i == 24)) begin n_bad++; $display("FAIL wrap_y%0d: got %h last=%b required %h last=%b", i, d, l, e, (i == 24)); end
    end
    count_done(6, nd);
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL wrap_done: got %0d pulses required 1", nd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d, e;
    logic l;
    bit ok;
    int nd;
    for (int k = 0; k < NUM_TAP; k++) tap_mem[k] = DW'($urandom_range(2000)) - 32'd1000;
    model_clear();
    start_run(32'd5);
    send_sample($urandom, ok);
    repeat (4) @(negedge axis_clk);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    n_cmp++;
    if (ap_idle !== 1'b1 || sm_tvalid !== 1'b0 || ap_done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state: ap_idle=%b sm_tvalid=%b ap_done=%b required 1 0 0", ap_idle, sm_tvalid, ap_done);
    end
    axis_rst = 1'b0;
    count_done(20, nd);
    n_cmp++;
    if (nd !== 0 || sm_tvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_nodone: done=%0d sm_tvalid=%b required 0 0", nd, sm_tvalid); end
    model_clear();
    start_run(32'd4);
    for (int i = 0; i < 4; i++) begin
      send_sample($urandom, ok);
      take_result(d, l, ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL midrst_out: no sm_tvalid for sample %0d", i); return; end
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== e || l !== (i == 3)) begin n_bad++; $display("FAIL midrst_y%0d: got %h last=%b required %h last=%b", i, d, l, e, (i == 3)); end
    end
    count_done(6, nd);
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL midrst_done: got %0d pulses required 1", nd); end
  endtask

  task automatic test_saturate();
    logic [DW-1:0] d, e;
    logic l;
    bit ok;
    for (int k = 0; k < NUM_TAP; k++) tap_mem[k] = 32'h40000000;
    model_clear();
    start_run(32'd2);
    for (int i = 0; i < 2; i++) begin
      send_sample(32'd1, ok);
      take_result(d, l, ok);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL sat_out: no sm_tvalid for sample %0d", i); return; end
      void'(exp_q.pop_front());
`ifdef FIR_SAT_EN
      e = (i == 0) ? 32'h40000000 : 32'h7FFFFFFF;
`else
      e = (i == 0) ? 32'h40000000 : 32'h80000000;
`endif
      n_cmp++;
      if (d !== e) begin n_bad++; $display("FAIL sat_y%0d: got %h required %h", i, d, e); end
    end
    repeat (4) @(negedge axis_clk);
  endtask

  task automatic test_zero_length();
    int nd;
    start_run(32'd0);
    count_done(20, nd);
    n_cmp++;
    if (nd !== 1 || ap_idle !== 1'b1) begin n_bad++; $display("FAIL zero_len: done=%0d ap_idle=%b required 1 and 1", nd, ap_idle); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) tap_mem[i] = '0;
    test_reset();
    test_impulse();
    test_second_run();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_saturate();
    test_zero_length();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
